// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine bank controller.
package slot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBIT,
    WAIT_REELS,
    EVAL,
    CREDIT
  } state_t;

  localparam int unsigned BET_1   = 1;
  localparam int unsigned BET_10  = 10;
  localparam int unsigned BET_50  = 50;
  localparam int unsigned BET_100 = 100;

  localparam int unsigned DEF_JACKPOT_MULT = 100;
  localparam int unsigned DEF_NEAR_MULT    = 2;

  // Switch order is {b100, b50, b10, b1}; the largest set switch wins.
  function automatic logic [6:0] bet_decode(input logic [3:0] sw);
    if (sw[3])      return 7'(BET_100);
    else if (sw[2]) return 7'(BET_50);
    else if (sw[1]) return 7'(BET_10);
    else if (sw[0]) return 7'(BET_1);
    else            return 7'd0;
  endfunction

endpackage

// File: rtl/slot_match_eval.sv
// Combinational count of reel digits equal to reel 0 (reel 0 always matches itself).
module slot_match_eval
  import slot_pkg::*;
#(
  parameter int NUM_REELS = 4,
  parameter int DIGIT_W   = 4,
  parameter int CNT_W     = $clog2(NUM_REELS + 1)
) (
  input  logic [NUM_REELS*DIGIT_W-1:0] reels,
  output logic [CNT_W-1:0]             match_cnt
);

  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < NUM_REELS; i++) begin
      if (reels[i*DIGIT_W +: DIGIT_W] == reels[DIGIT_W-1:0]) begin
        match_cnt += CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/slot_bank_ctrl.sv
// Slot machine bank: debit bet, wait for reels, evaluate match, credit saturating payout.
// Spin-to-credit is 4 cycles plus reel wait; spin while busy is dropped, never queued.
module slot_bank_ctrl
  import slot_pkg::*;
#(
  parameter int NUM_REELS    = 4,
  parameter int DIGIT_W      = 4,
  parameter int BAL_W        = 27,
  parameter int START_BAL    = 100,
  parameter int JACKPOT_MULT = DEF_JACKPOT_MULT,
  parameter int NEAR_MULT    = DEF_NEAR_MULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   bet_sw,
  input  logic                         spin,
  input  logic [NUM_REELS*DIGIT_W-1:0] reels,
  input  logic                         reels_valid,
  output logic [BAL_W-1:0]             balance,
  output logic                         busy,
  output logic                         win,
  output logic                         jackpot,
  output logic                         no_funds,
  output logic [BAL_W-1:0]             last_payout
);

  localparam int CNT_W = $clog2(NUM_REELS + 1);
  localparam int PW    = 2 * BAL_W;
  localparam logic [BAL_W-1:0] BAL_MAX = '1;

  state_t                         state;
  logic [BAL_W-1:0]               bet_now;
  logic [BAL_W-1:0]               bet_q;
  logic [NUM_REELS*DIGIT_W-1:0]   reels_q;
  logic [CNT_W-1:0]               match_cnt;
  logic                           is_jack;
  logic                           jack_q;
  logic [PW-1:0]                  mult;
  logic [PW-1:0]                  product;
  logic [BAL_W-1:0]               payout_sat;
  logic [BAL_W-1:0]               payout_q;
  logic [BAL_W:0]                 sum;
  logic [BAL_W-1:0]               credit_bal;

  assign bet_now = BAL_W'(bet_decode(bet_sw));

  slot_match_eval #(
    .NUM_REELS (NUM_REELS),
    .DIGIT_W   (DIGIT_W),
    .CNT_W     (CNT_W)
  ) u_match (
    .reels     (reels_q),
    .match_cnt (match_cnt)
  );

  // Product is formed at double width so a large multiplier can only saturate, never wrap.
  always_comb begin
    is_jack = (match_cnt == CNT_W'(NUM_REELS));
    mult    = '0;
    if (is_jack)                                 mult = PW'(JACKPOT_MULT);
    else if (match_cnt == CNT_W'(NUM_REELS - 1)) mult = PW'(NEAR_MULT);
    product    = PW'(bet_q) * mult;
    payout_sat = (product > PW'(BAL_MAX)) ? BAL_MAX : product[BAL_W-1:0];
    sum        = {1'b0, balance} + {1'b0, payout_q};
    credit_bal = sum[BAL_W] ? BAL_MAX : sum[BAL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      balance     <= BAL_W'(START_BAL);
      last_payout <= '0;
      busy        <= 1'b0;
      win         <= 1'b0;
      jackpot     <= 1'b0;
      no_funds    <= 1'b0;
      bet_q       <= '0;
      reels_q     <= '0;
      payout_q    <= '0;
      jack_q      <= 1'b0;
    end else begin
      win      <= 1'b0;
      jackpot  <= 1'b0;
      no_funds <= 1'b0;
      case (state)
        IDLE: begin
          if (spin && (bet_now != '0)) begin
            if (bet_now > balance) begin
              no_funds <= 1'b1;
            end else begin
              bet_q <= bet_now;
              busy  <= 1'b1;
              state <= DEBIT;
            end
          end
        end
        DEBIT: begin
          balance <= balance - bet_q;
          state   <= WAIT_REELS;
        end
        WAIT_REELS: begin
          if (reels_valid) begin
            reels_q <= reels;
            state   <= EVAL;
          end
        end
        EVAL: begin
          payout_q <= payout_sat;
          jack_q   <= is_jack;
          state    <= CREDIT;
        end
        CREDIT: begin
          balance     <= credit_bal;
          last_payout <= payout_q;
          win         <= (payout_q != '0);
          jackpot     <= jack_q;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slot_bank_ctrl.sv
// Directed bench for slot_bank_ctrl: default build, near-saturation build and a 3-reel build.
module tb_slot_bank_ctrl;

  localparam int SAT_START = 134217677;  // 2^27-1 minus 50

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spin = 1'b0;
  logic        reels_valid = 1'b0;
  logic [3:0]  bet_sw = 4'b0000;
  logic [15:0] reels = 16'h0000;

  logic [26:0] m_balance, m_last_payout, s_balance, s_last_payout, t_balance, t_last_payout;
  logic        m_busy, m_win, m_jackpot, m_no_funds;
  logic        s_busy, s_win, s_jackpot, s_no_funds;
  logic        t_busy, t_win, t_jackpot, t_no_funds;

  int n_chk  = 0;
  int n_fail = 0;
  logic        spin_busy;
  logic [26:0] mid_bal;

  always #5 clk = ~clk;

  slot_bank_ctrl u_main (
    .clk(clk), .rst(rst), .bet_sw(bet_sw), .spin(spin), .reels(reels),
    .reels_valid(reels_valid), .balance(m_balance), .busy(m_busy), .win(m_win),
    .jackpot(m_jackpot), .no_funds(m_no_funds), .last_payout(m_last_payout)
  );

  slot_bank_ctrl #(.START_BAL(SAT_START)) u_sat (
    .clk(clk), .rst(rst), .bet_sw(bet_sw), .spin(spin), .reels(reels),
    .reels_valid(reels_valid), .balance(s_balance), .busy(s_busy), .win(s_win),
    .jackpot(s_jackpot), .no_funds(s_no_funds), .last_payout(s_last_payout)
  );

  slot_bank_ctrl #(.NUM_REELS(3)) u_r3 (
    .clk(clk), .rst(rst), .bet_sw(bet_sw), .spin(spin), .reels(reels[11:0]),
    .reels_valid(reels_valid), .balance(t_balance), .busy(t_busy), .win(t_win),
    .jackpot(t_jackpot), .no_funds(t_no_funds), .last_payout(t_last_payout)
  );

  typedef struct {
    bit          do_rst;
    logic [3:0]  bet;
    logic [15:0] rv;     // reel 0 is the LSB nibble
    bit          go;
    bit          nf;
    int          mid;
    int          bal;
    bit          w;
    bit          j;
    int          lp;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; spin = 1'b0; reels_valid = 1'b0; bet_sw = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Returns at the negedge where the outcome (no_funds or credit pulses) is visible.
  task automatic do_spin(input logic [3:0] bet, input logic [15:0] rv, input bit go);
    @(negedge clk);
    bet_sw = bet; spin = 1'b1; reels = rv;
    @(negedge clk);
    spin = 1'b0; bet_sw = 4'b1000;
    spin_busy = m_busy;
    if (go) begin
      @(negedge clk);
      mid_bal = m_balance;
      @(negedge clk);
      reels_valid = 1'b1;
      @(negedge clk);
      reels_valid = 1'b0; reels = ~rv;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b1, 4'b0010, 16'h7777, 1'b1, 1'b0, 90,   1090,  1'b1, 1'b1, 1000};
    tv[1] = '{1'b1, 4'b0100, 16'h3733, 1'b1, 1'b0, 50,   150,   1'b1, 1'b0, 100};
    tv[2] = '{1'b1, 4'b1000, 16'h4321, 1'b1, 1'b0, 0,    0,     1'b0, 1'b0, 0};
    tv[3] = '{1'b0, 4'b0001, 16'h0000, 1'b0, 1'b1, 0,    0,     1'b0, 1'b0, 0};
    tv[4] = '{1'b1, 4'b0000, 16'h1111, 1'b0, 1'b0, 0,    100,   1'b0, 1'b0, 0};
    tv[5] = '{1'b1, 4'b1111, 16'h0000, 1'b1, 1'b0, 0,    10000, 1'b1, 1'b1, 10000};
    tv[6] = '{1'b0, 4'b0110, 16'h5A5A, 1'b1, 1'b0, 9950, 9950,  1'b0, 1'b0, 0};
    tv[7] = '{1'b0, 4'b0011, 16'h8988, 1'b1, 1'b0, 9940, 9960,  1'b1, 1'b0, 20};

    for (int i = 0; i < 8; i++) begin
      if (tv[i].do_rst) begin
        apply_reset();
        chk("rst_balance", m_balance, 100);
        chk("rst_last_payout", m_last_payout, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_flags", {m_win, m_jackpot, m_no_funds}, 0);
      end
      do_spin(tv[i].bet, tv[i].rv, tv[i].go);
      if (tv[i].go) begin
        chk($sformatf("v%0d_busy_after_spin", i), spin_busy, 1);
        chk($sformatf("v%0d_debit_balance", i), mid_bal, tv[i].mid);
      end else begin
        chk($sformatf("v%0d_no_funds", i), m_no_funds, tv[i].nf);
      end
      chk($sformatf("v%0d_balance", i), m_balance, tv[i].bal);
      chk($sformatf("v%0d_win", i), m_win, tv[i].w);
      chk($sformatf("v%0d_jackpot", i), m_jackpot, tv[i].j);
      chk($sformatf("v%0d_last_payout", i), m_last_payout, tv[i].lp);
      chk($sformatf("v%0d_busy_idle", i), m_busy, 0);
      @(negedge clk);
      chk($sformatf("v%0d_pulses_clear", i), {m_win, m_jackpot, m_no_funds}, 0);
    end

    // Reels pulse during DEBIT and spin during WAIT_REELS must both be ignored.
    apply_reset();
    @(negedge clk);
    bet_sw = 4'b0001; spin = 1'b1;
    @(negedge clk);
    spin = 1'b0; reels_valid = 1'b1; reels = 16'h2222;
    @(negedge clk);
    reels_valid = 1'b0; spin = 1'b1; bet_sw = 4'b0010;
    @(negedge clk);
    spin = 1'b0;
    chk("a_busy_waiting", m_busy, 1);
    chk("a_balance_debited", m_balance, 99);
    @(negedge clk);
    chk("a_still_waiting", m_busy, 1);
    reels = 16'h1111; reels_valid = 1'b1;
    @(negedge clk);
    reels_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("a_balance_credit", m_balance, 199);
    chk("a_jackpot", m_jackpot, 1);
    chk("a_last_payout", m_last_payout, 100);
    @(negedge clk);
    chk("a_spin_not_queued", m_busy, 0);
    reels_valid = 1'b1;
    @(negedge clk);
    reels_valid = 1'b0;
    chk("a_idle_reels_ignored", m_busy, 0);
    chk("a_idle_balance", m_balance, 199);

    // Reset in WAIT_REELS, coincident with reels_valid and spin: no refund, no credit.
    apply_reset();
    @(negedge clk);
    bet_sw = 4'b0010; spin = 1'b1;
    @(negedge clk);
    spin = 1'b0;
    @(negedge clk);
    chk("b_balance_debited", m_balance, 90);
    rst = 1'b0; reels_valid = 1'b1; reels = 16'h7777; spin = 1'b1;
    @(negedge clk);
    rst = 1'b1; reels_valid = 1'b0; spin = 1'b0; bet_sw = 4'b0000;
    chk("b_balance_reset", m_balance, 100);
    chk("b_busy_reset", m_busy, 0);
    chk("b_win_reset", m_win, 0);
    reels_valid = 1'b1;
    @(negedge clk);
    reels_valid = 1'b0;
    chk("b_late_reels_busy", m_busy, 0);
    @(negedge clk);
    @(negedge clk);
    chk("b_late_reels_win", m_win, 0);
    chk("b_late_reels_balance", m_balance, 100);

    // Saturating credit and the 3-reel build.
    apply_reset();
    chk("s_rst_balance", s_balance, SAT_START);
    do_spin(4'b1000, 16'h0000, 1'b1);
    chk("s_balance_sat", s_balance, 134217727);
    chk("s_jackpot", s_jackpot, 1);
    chk("s_last_payout", s_last_payout, 10000);
    chk("t_jackpot_000", t_jackpot, 1);
    chk("t_balance_000", t_balance, 10000);

    apply_reset();
    do_spin(4'b0001, 16'h0555, 1'b1);
    chk("t_jackpot_555", t_jackpot, 1);
    chk("t_balance_555", t_balance, 199);
    do_spin(4'b0001, 16'h0655, 1'b1);
    chk("t_win_556", t_win, 1);
    chk("t_jackpot_556", t_jackpot, 0);
    chk("t_last_payout_556", t_last_payout, 2);
    chk("t_balance_556", t_balance, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
